// File: rtl/smpl_scb.sv
// In-order sample-test scoreboard: golden edge-function hit masks queued and compared
// against variable-latency DUT results. Optional capture: SMPL_SCB_MISMATCH_CAPTURE_EN.
module smpl_scb #(
    parameter int SIGFIG  = 24,
    parameter int RADIX   = 10,
    parameter int VERTS   = 3,
    parameter int AXIS    = 3,
    parameter int SAMPS   = 4,
    parameter int DEPTH   = 8,
    parameter int MAX_LAT = 32,
    parameter int CNTW    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      validSamp_R16H,
    input  logic signed [SIGFIG-1:0]  tri_R16S    [VERTS-1:0][AXIS-1:0],
    input  logic signed [SIGFIG-1:0]  sample_R16S [1:0][SAMPS-1:0],
    input  logic                      res_valid_R18H,
    input  logic [SAMPS-1:0]          hit_valid_R18H,
    output logic [CNTW-1:0]           match_cnt,
    output logic [CNTW-1:0]           err_cnt,
    output logic                      err_sticky,
    output logic                      spurious,
    output logic                      overflow,
    output logic                      timeout,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      idle
`ifdef SMPL_SCB_MISMATCH_CAPTURE_EN
    ,
    output logic [SAMPS-1:0]          first_exp,
    output logic [SAMPS-1:0]          first_act,
    output logic [CNTW-1:0]           first_idx,
    output logic                      first_vld
`endif
);

    localparam int DW = SIGFIG + 1;
    localparam int EW = 2 * SIGFIG + 3;
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int GW = $clog2(MAX_LAT + 1);
    localparam int unused_radix = RADIX;

    // Stage 1: edge vectors and sample offsets per vertex
    logic                  v1_q;
    logic signed [DW-1:0]  dx_q [3];
    logic signed [DW-1:0]  dy_q [3];
    logic signed [DW-1:0]  sx_q [SAMPS][3];
    logic signed [DW-1:0]  sy_q [SAMPS][3];

    // Stage 2: edge functions and hit mask
    logic signed [EW-1:0]  e;
    logic [2:0]            neg;
    logic [2:0]            zer;
    logic [SAMPS-1:0]      mask;

    logic [SAMPS-1:0]      mem [DEPTH];
    logic [AW-1:0]         wptr_q;
    logic [AW-1:0]         rptr_q;
    logic [OW-1:0]         occ_q;
    logic [GW-1:0]         age_q;
    logic [GW-1:0]         age_d;
    logic [SAMPS-1:0]      head;
    logic                  has;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  spur;
    logic                  wr;
    logic                  drop;
    logic                  mism;
    logic                  err_ev;
    logic                  unused_z;

    always_comb begin
        unused_z = 1'b0;
        for (int unsigned k = 0; k < VERTS; k++) begin
            for (int unsigned a = 2; a < AXIS; a++) begin
                unused_z = unused_z ^ (^tri_R16S[k][a]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (validSamp_R16H) begin
            for (int unsigned k = 0; k < 3; k++) begin
                dx_q[k] <= DW'(tri_R16S[(k+1)%3][0]) - DW'(tri_R16S[k][0]);
                dy_q[k] <= DW'(tri_R16S[(k+1)%3][1]) - DW'(tri_R16S[k][1]);
                for (int unsigned i = 0; i < SAMPS; i++) begin
                    sx_q[i][k] <= DW'(sample_R16S[0][i]) - DW'(tri_R16S[k][0]);
                    sy_q[i][k] <= DW'(sample_R16S[1][i]) - DW'(tri_R16S[k][1]);
                end
            end
        end
    end

    // Clockwise, top-left: edges 0 and 2 accept zero, edge 1 is strict
    always_comb begin
        mask = '0;
        e    = '0;
        neg  = '0;
        zer  = '0;
        for (int unsigned i = 0; i < SAMPS; i++) begin
            for (int unsigned k = 0; k < 3; k++) begin
                e = EW'(dx_q[k]) * EW'(sy_q[i][k]) - EW'(dy_q[k]) * EW'(sx_q[i][k]);
                neg[k] = e[EW-1];
                zer[k] = (e == '0);
            end
            mask[i] = (neg[0] | zer[0]) & neg[1] & (neg[2] | zer[2]);
        end
    end

    assign push   = v1_q;
    assign has    = (occ_q != '0);
    assign full   = (occ_q == OW'(DEPTH));
    assign pop    = res_valid_R18H && has;
    assign spur   = res_valid_R18H && !has;
    assign wr     = push && (!full || pop);
    assign drop   = push && full && !pop;
    assign head   = mem[rptr_q];
    assign mism   = pop && (head != hit_valid_R18H);
    assign err_ev = mism || spur;

    always_comb begin
        if (pop || !has)
            age_d = '0;
        else if (age_q == GW'(MAX_LAT))
            age_d = age_q;
        else
            age_d = age_q + 1'b1;
    end

    // A write while full is only reached together with a pop, so it reuses the slot being read
    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr_q] <= mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q       <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            age_q      <= '0;
            match_cnt  <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
            spurious   <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            v1_q     <= validSamp_R16H;
            spurious <= spur;
            age_q    <= age_d;
            if (age_d == GW'(MAX_LAT))
                timeout <= 1'b1;
            if (drop)
                overflow <= 1'b1;
            if (wr)
                wptr_q <= wptr_q + 1'b1;
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            if (wr && !pop)
                occ_q <= occ_q + 1'b1;
            else if (pop && !wr)
                occ_q <= occ_q - 1'b1;
            if (pop && !mism && match_cnt != '1)
                match_cnt <= match_cnt + 1'b1;
            if (err_ev) begin
                err_sticky <= 1'b1;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef SMPL_SCB_MISMATCH_CAPTURE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_exp <= '0;
            first_act <= '0;
            first_idx <= '0;
            first_vld <= 1'b0;
        end else if (err_ev && !first_vld) begin
            first_exp <= spur ? '0 : head;
            first_act <= hit_valid_R18H;
            first_idx <= match_cnt + err_cnt;
            first_vld <= 1'b1;
        end
    end
`endif

    assign occupancy = occ_q;
    assign idle      = !has && !v1_q;

endmodule

// File: tb/tb_smpl_scb.sv
// Directed and randomized checks of smpl_scb against a queue-based model of the
// golden edge test, FIFO, counters, age and sticky flags.
module tb_smpl_scb;

    localparam int SIGFIG  = 24;
    localparam int SAMPS   = 4;
    localparam int DEPTH   = 8;
    localparam int MAX_LAT = 32;
    localparam int CNTW    = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     validSamp_R16H = 1'b0;
    logic signed [SIGFIG-1:0] tri_s    [2:0][2:0];
    logic signed [SIGFIG-1:0] sample_s [1:0][SAMPS-1:0];
    logic                     res_valid_R18H = 1'b0;
    logic [SAMPS-1:0]         hit_valid_R18H = '0;
    logic [CNTW-1:0]          match_cnt;
    logic [CNTW-1:0]          err_cnt;
    logic                     err_sticky;
    logic                     spurious;
    logic                     overflow;
    logic                     timeout;
    logic [$clog2(DEPTH):0]   occupancy;
    logic                     idle;
`ifdef SMPL_SCB_MISMATCH_CAPTURE_EN
    logic [SAMPS-1:0]         first_exp;
    logic [SAMPS-1:0]         first_act;
    logic [CNTW-1:0]          first_idx;
    logic                     first_vld;
`endif

    smpl_scb #(
        .SIGFIG(SIGFIG), .RADIX(10), .VERTS(3), .AXIS(3), .SAMPS(SAMPS),
        .DEPTH(DEPTH), .MAX_LAT(MAX_LAT), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .validSamp_R16H(validSamp_R16H),
        .tri_R16S(tri_s), .sample_R16S(sample_s),
        .res_valid_R18H(res_valid_R18H), .hit_valid_R18H(hit_valid_R18H),
        .match_cnt(match_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky),
        .spurious(spurious), .overflow(overflow), .timeout(timeout),
        .occupancy(occupancy), .idle(idle)
`ifdef SMPL_SCB_MISMATCH_CAPTURE_EN
        , .first_exp(first_exp), .first_act(first_act),
        .first_idx(first_idx), .first_vld(first_vld)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Current stimulus as plain integers
    longint cur_vx [3];
    longint cur_vy [3];
    longint cur_sx [SAMPS];
    longint cur_sy [SAMPS];

    // Reference model state
    bit [SAMPS-1:0] q [$];
    int             m_match, m_err, m_age, m_peak;
    bit             m_sticky, m_spur, m_ovf, m_tmo;
    bit             pend_v;
    bit [SAMPS-1:0] pend_m;
    bit             cap_v;
    bit [SAMPS-1:0] cap_exp, cap_act;
    int             cap_idx;

    bit [SAMPS-1:0] sets [16];
    int             dut_peak;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [SAMPS-1:0] golden();
        bit [SAMPS-1:0] m;
        longint ev [3];
        m = '0;
        for (int i = 0; i < SAMPS; i++) begin
            for (int k = 0; k < 3; k++) begin
                int j;
                j = (k + 1) % 3;
                ev[k] = (cur_vx[j] - cur_vx[k]) * (cur_sy[i] - cur_vy[k])
                      - (cur_vy[j] - cur_vy[k]) * (cur_sx[i] - cur_vx[k]);
            end
            m[i] = (ev[0] <= 0) && (ev[1] < 0) && (ev[2] <= 0);
        end
        return m;
    endfunction

    task automatic drive_cur();
        for (int k = 0; k < 3; k++) begin
            tri_s[k][0] = SIGFIG'(cur_vx[k]);
            tri_s[k][1] = SIGFIG'(cur_vy[k]);
            tri_s[k][2] = SIGFIG'($urandom);
        end
        for (int i = 0; i < SAMPS; i++) begin
            sample_s[0][i] = SIGFIG'(cur_sx[i]);
            sample_s[1][i] = SIGFIG'(cur_sy[i]);
        end
    endtask

    function automatic longint rnd(input int unsigned half);
        return longint'($urandom_range(0, 2 * half - 1)) - longint'(half);
    endfunction

    task automatic rand_set(input int unsigned half);
        for (int k = 0; k < 3; k++) begin
            cur_vx[k] = rnd(half);
            cur_vy[k] = rnd(half);
        end
        for (int i = 0; i < SAMPS; i++) begin
            cur_sx[i] = rnd(half);
            cur_sy[i] = rnd(half);
        end
        drive_cur();
    endtask

    task automatic set_basic();
        cur_vx = '{0, 0, 4096};
        cur_vy = '{0, 4096, 0};
        cur_sx = '{512, 3072, -1, 0};
        cur_sy = '{512, 3072, 5, 0};
        drive_cur();
    endtask

    task automatic model_clear();
        q.delete();
        m_match = 0; m_err = 0; m_age = 0; m_peak = 0;
        m_sticky = 0; m_spur = 0; m_ovf = 0; m_tmo = 0;
        pend_v = 0; pend_m = '0;
        cap_v = 0; cap_exp = '0; cap_act = '0; cap_idx = 0;
        dut_peak = 0;
    endtask

    task automatic check_all();
        chk("occupancy", occupancy, q.size());
        chk("match_cnt", match_cnt, m_match);
        chk("err_cnt", err_cnt, m_err);
        chk("err_sticky", err_sticky, m_sticky);
        chk("spurious", spurious, m_spur);
        chk("overflow", overflow, m_ovf);
        chk("timeout", timeout, m_tmo);
        chk("idle", idle, (q.size() == 0 && !pend_v));
`ifdef SMPL_SCB_MISMATCH_CAPTURE_EN
        chk("first_vld", first_vld, cap_v);
        chk("first_exp", first_exp, cap_exp);
        chk("first_act", first_act, cap_act);
        chk("first_idx", first_idx, cap_idx);
`endif
        if (int'(occupancy) > dut_peak) dut_peak = int'(occupancy);
    endtask

    // One clock cycle: advance the model with the inputs now applied, then check
    task automatic step();
        bit pop, spur, mism;
        int sz;
        sz   = q.size();
        pop  = res_valid_R18H && sz > 0;
        spur = res_valid_R18H && sz == 0;
        mism = pop ? (q[0] != hit_valid_R18H) : 1'b0;
        if ((mism || spur) && !cap_v) begin
            cap_v   = 1;
            cap_exp = spur ? '0 : q[0];
            cap_act = hit_valid_R18H;
            cap_idx = m_match + m_err;
        end
        if (pop && !mism) m_match++;
        if (mism || spur) begin
            m_err++;
            m_sticky = 1;
        end
        m_spur = spur;
        if (pop || sz == 0) m_age = 0;
        else if (m_age < MAX_LAT) m_age++;
        if (m_age == MAX_LAT) m_tmo = 1;
        if (pop) void'(q.pop_front());
        if (pend_v) begin
            if (sz < DEPTH || pop) q.push_back(pend_m);
            else m_ovf = 1;
        end
        pend_v = validSamp_R16H;
        pend_m = golden();
        if (q.size() > m_peak) m_peak = q.size();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        validSamp_R16H = 0;
        res_valid_R18H = 0;
        hit_valid_R18H = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            cur_vx[k] = 0; cur_vy[k] = 0;
        end
        for (int i = 0; i < SAMPS; i++) begin
            cur_sx[i] = 0; cur_sy[i] = 0;
        end
        drive_cur();
        model_clear();

        // Basic hit/miss, latency 2, correct bits
        do_reset();
        set_basic();
        validSamp_R16H = 1; step();
        validSamp_R16H = 0; step();
        res_valid_R18H = 1; hit_valid_R18H = 4'b1001; step();
        idle_inputs(); step();
        chk("basic_match", match_cnt, 1);
        chk("basic_err", err_cnt, 0);

        // Mismatch on bit 1
        do_reset();
        set_basic();
        validSamp_R16H = 1; step();
        validSamp_R16H = 0; step();
        res_valid_R18H = 1; hit_valid_R18H = 4'b1011; step();
        idle_inputs(); step();
        chk("mism_err", err_cnt, 1);
        chk("mism_sticky", err_sticky, 1);
        chk("mism_match", match_cnt, 0);
`ifdef SMPL_SCB_MISMATCH_CAPTURE_EN
        chk("mism_cap_diff", first_exp ^ first_act, 4'b0010);
        chk("mism_cap_idx", first_idx, 0);
        chk("mism_cap_exp", first_exp, 4'b1001);
`endif

        // Back-to-back: 6 sets at latency 7, then 3 sets at latency 2
        do_reset();
        begin
            int pres [9] = '{0, 1, 2, 3, 4, 5, 13, 14, 15};
            int lat  [9] = '{7, 7, 7, 7, 7, 7, 2, 2, 2};
            for (int c = 0; c < 21; c++) begin
                idle_inputs();
                for (int j = 0; j < 9; j++) begin
                    if (pres[j] == c) begin
                        rand_set(4096);
                        sets[j] = golden();
                        validSamp_R16H = 1;
                    end
                end
                for (int j = 0; j < 9; j++) begin
                    if (pres[j] + lat[j] == c) begin
                        res_valid_R18H = 1;
                        hit_valid_R18H = sets[j];
                    end
                end
                step();
            end
        end
        chk("b2b_peak", dut_peak, m_peak);
        chk("b2b_match", match_cnt, 9);
        chk("b2b_idle", idle, 1);

        // Full boundary: push/pop at full, then a dropped push
        do_reset();
        for (int c = 0; c < 12; c++) begin
            idle_inputs();
            if (c < 10) begin
                rand_set(4096);
                sets[c] = golden();
                validSamp_R16H = 1;
            end
            if (c == 9) begin
                res_valid_R18H = 1;
                hit_valid_R18H = sets[0];
            end
            step();
            if (c == 9) begin
                chk("full_pushpop_occ", occupancy, DEPTH);
                chk("full_pushpop_ovf", overflow, 0);
            end
        end
        chk("ovf_flag", overflow, 1);
        chk("ovf_occ", occupancy, DEPTH);
        for (int c = 0; c < DEPTH + 2; c++) begin
            idle_inputs();
            if (q.size() > 0) begin
                res_valid_R18H = 1;
                hit_valid_R18H = q[0];
            end
            step();
        end
        chk("ovf_drain_idle", idle, 1);

        // Spurious result while a push completes, then timeout on the queued entry
        do_reset();
        rand_set(4096);
        validSamp_R16H = 1; step();
        validSamp_R16H = 0;
        res_valid_R18H = 1; hit_valid_R18H = 4'b0101; step();
        chk("spur_pulse", spurious, 1);
        chk("spur_err", err_cnt, 1);
        chk("spur_push_occ", occupancy, 1);
        idle_inputs(); step();
        chk("spur_end", spurious, 0);
`ifdef SMPL_SCB_MISMATCH_CAPTURE_EN
        chk("spur_cap_exp", first_exp, 0);
        chk("spur_cap_act", first_act, 4'b0101);
`endif
        for (int c = 0; c < 30; c++) step();
        chk("tmo_early", timeout, 0);
        for (int c = 0; c < 4; c++) step();
        chk("tmo_set", timeout, 1);
        res_valid_R18H = 1; hit_valid_R18H = q[0]; step();
        idle_inputs(); step();
        chk("tmo_sticky", timeout, 1);

        // Asynchronous reset with three entries queued
        do_reset();
        for (int c = 0; c < 3; c++) begin
            rand_set(4096);
            validSamp_R16H = 1;
            step();
        end
        idle_inputs(); step();
        chk("pre_rst_occ", occupancy, 3);
        #3;
        rst = 0;
        #1;
        chk("arst_occ", occupancy, 0);
        chk("arst_match", match_cnt, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_flags", {err_sticky, spurious, overflow, timeout}, 0);
        chk("arst_idle", idle, 1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        rand_set(4096);
        sets[0] = golden();
        validSamp_R16H = 1; step();
        validSamp_R16H = 0; step();
        res_valid_R18H = 1; hit_valid_R18H = sets[0]; step();
        idle_inputs(); step();
        chk("post_rst_match", match_cnt, 1);

        // Randomized traffic, including full-range coordinates and injected errors
        do_reset();
        for (int c = 0; c < 300; c++) begin
            idle_inputs();
            rand_set(($urandom_range(0, 3) == 0) ? (1 << 23) : 4096);
            validSamp_R16H = 1'($urandom_range(0, 1));
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                res_valid_R18H = 1;
                hit_valid_R18H = q[0];
                if ($urandom_range(0, 7) == 0) hit_valid_R18H[$urandom_range(0, SAMPS - 1)] ^= 1'b1;
            end else if (q.size() == 0 && $urandom_range(0, 19) == 0) begin
                res_valid_R18H = 1;
                hit_valid_R18H = 4'($urandom);
            end
            step();
        end
        for (int c = 0; c < DEPTH + 4; c++) begin
            idle_inputs();
            if (q.size() > 0) begin
                res_valid_R18H = 1;
                hit_valid_R18H = q[0];
            end
            step();
        end
        chk("rand_idle", idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
